// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state/byte types, S-box tables and byte indexing.
// The sub_bytes, shift_rows and mix_columns stages all import this package.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [7:0]             aes_byte_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} sub_state_e;

    localparam aes_byte_t SBOX_FWD [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam aes_byte_t SBOX_INV [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    // Byte 0 is the most significant byte of the state.
    function automatic aes_byte_t byte_sel(input aes_state_t state, input int unsigned idx);
        return state[AES_STATE_W-1-8*idx -: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, forward or inverse selected per use.
module aes_sbox
    import aes_pkg::*;
(
    input  logic      fwd_ninv_i,
    input  aes_byte_t in_byte,
    output aes_byte_t out_byte
);

    assign out_byte = fwd_ninv_i ? SBOX_FWD[in_byte] : SBOX_INV[in_byte];

endmodule

// File: rtl/aes_sub_bytes.sv
// Iterative SubBytes/InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock in place,
// then holds the finished state until the downstream stage takes it.
module aes_sub_bytes
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fwd_ninv_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  aes_state_t in_state_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output aes_state_t out_state_o,
    output logic       busy_o
);

    localparam int N_CHUNKS = AES_NBYTES / BYTES_PER_CYCLE;
    localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CHUNKS - 1);

    generate
        if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
            BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
            $error("aes_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sub_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    aes_state_t       work_q, work_d;

    logic [4:0]                            base;
    logic [BYTES_PER_CYCLE-1:0][7:0]       lane_in;
    logic [BYTES_PER_CYCLE-1:0][7:0]       lane_out;

    // First byte index of the chunk being substituted this cycle.
    assign base = 5'(cnt_q) * 5'(BYTES_PER_CYCLE);

    genvar g;
    generate
        for (g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
            assign lane_in[g] = byte_sel(work_q, 32'(base) + g);
            aes_sbox u_sbox (
                .fwd_ninv_i (mode_q),
                .in_byte    (lane_in[g]),
                .out_byte   (lane_out[g])
            );
        end
    endgenerate

    assign in_ready_o  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready_i);
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q == ST_RUN);
    assign out_state_o = work_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        case (state_q)
            ST_RUN: begin
                for (int i = 0; i < BYTES_PER_CYCLE; i++)
                    work_d[AES_STATE_W-1-8*(int'(base)+i) -: 8] = lane_out[i];
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: if (out_ready_i) state_d = ST_IDLE;
            default: ;
        endcase
        // An accept in DONE overrides the return to IDLE (back-to-back blocks).
        if (in_valid_i && in_ready_o) begin
            work_d  = in_state_i;
            mode_d  = fwd_ninv_i;
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b1;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
        end
    end

endmodule

// File: doc/aes_sub_bytes.md
Name: aes_sub_bytes

Overview:
Iterative AES SubBytes / InvSubBytes stage. It sits directly upstream of shift_rows in the round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through shared S-box instances. It holds the result until the downstream stage accepts it.

Parameters:
- BYTES_PER_CYCLE, 4, bytes substituted per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- N_CHUNKS, 16/BYTES_PER_CYCLE, derived (localparam), number of RUN cycles per block.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- fwd_ninv_i  input  1  1 = forward S-box (encrypt), 0 = inverse S-box (decrypt). Sampled only on input handshake.
- in_valid_i  input  1  in_state_i is valid.
- in_ready_o  output  1  block can accept a state.
- in_state_i  input  128  input state. Byte 0 = [127:120], byte 15 = [7:0].
- out_valid_o  output  1  out_state_o holds a completed result.
- out_ready_i  input  1  downstream (shift_rows) accepts the result.
- out_state_o  output  128  substituted state, same byte order as the input.
- busy_o  output  1  high in RUN.

Behaviour:
- States are IDLE, RUN and DONE. Registers are state, chunk counter cnt (clog2(N_CHUNKS) bits, min 1), mode_q, and work register work_q[127:0].
- Reset (rst_i=0, async) forces:
  - state=IDLE, cnt=0, mode_q=1, work_q=0.
  - Outputs: out_valid_o=0, out_state_o=0, busy_o=0, in_ready_o=1.
  - A reset asserted mid-operation aborts the block with no partial output.
- in_ready_o = (state==IDLE) || (state==DONE && out_ready_i). The path from out_ready_i to in_ready_o is combinational.
- Accept = in_valid_i && in_ready_o. On accept:
  - work_q <= in_state_i, mode_q <= fwd_ninv_i, cnt <= 0, state <= RUN.
- RUN, each cycle:
  - Bytes cnt*BPC .. cnt*BPC+BPC-1 of work_q are replaced by SBOX(mode_q, byte), in place.
  - If cnt==N_CHUNKS-1: state <= DONE, cnt <= 0. Otherwise cnt <= cnt+1.
  - in_valid_i is ignored in RUN.
- DONE:
  - out_valid_o=1 and out_state_o=work_q. Both stay stable while out_ready_i=0 (no retraction, no change).
  - out_ready_i=1 with no simultaneous accept: state <= IDLE.
  - out_ready_i=1 with a simultaneous accept: back-to-back; the new state loads and the next state is RUN.
- Latency: accept on edge k gives out_valid_o=1 after edge k+N_CHUNKS. Sustained throughput is one block per N_CHUNKS+1 cycles.
- BYTES_PER_CYCLE=16: RUN lasts exactly one cycle.
- Changes on fwd_ninv_i or in_state_i after accept have no effect on the block in flight.
- out_valid_o = (state==DONE) and busy_o = (state==RUN), both decoded from registered state.

Decomposition:
- aes_pkg holds the shared definitions:
  - AES_STATE_W=128, AES_NBYTES=16.
  - typedef aes_state_t (logic [127:0]) and aes_byte_t (logic [7:0]).
  - Constant arrays SBOX_FWD[256] and SBOX_INV[256].
  - Function byte_sel(state, idx), using MSB-first indexing.
  - shift_rows and the later mix_columns stage reuse this package.
- Sub-module aes_sbox is purely combinational: fwd_ninv_i, in_byte[7:0] -> out_byte[7:0].
  - It is instantiated BYTES_PER_CYCLE times via generate.
  - Byte select is a mux on cnt.

Test Plan:
- Forward FIPS-197 Appendix B, BPC=4:
  - Stimulus: in=193de3bea0f4e22b9ac68d2ae9f84808, fwd=1, accepted on edge k.
  - Response: out_valid_o rises after edge k+4; out=d42711aee0bf98f1b8b45de51e415230.
- Inverse round-trip:
  - Stimulus: in=d42711aee0bf98f1b8b45de51e415230, fwd=0.
  - Response: out=193de3bea0f4e22b9ac68d2ae9f84808.
- Single-byte corners, BPC=1:
  - Stimulus: in=00..00 fwd=1, then in=ff..ff fwd=1, then in=63..63 fwd=0.
  - Response: out=63..63, 16..16 and 00..00 respectively; each after 16 cycles.
- Backpressure:
  - Stimulus: hold out_ready_i=0 for 10 cycles after out_valid_o; toggle in_valid_i and in_state_i meanwhile.
  - Response: out_state_o unchanged; in_ready_o=0; no accept occurs.
- Back-to-back:
  - Stimulus: in_valid_i=1 held with 53..53 fwd=1, then 00..00 fwd=0; out_ready_i=1.
  - Response: ed..ed, then 52..52; in_ready_o=1 during DONE; gap of exactly N_CHUNKS+1 cycles between valids.
- Reset mid-RUN:
  - Stimulus: assert rst_i=0 at cnt=2 asynchronously, between edges.
  - Response: outputs immediately out_valid_o=0, out_state_o=0, busy_o=0, in_ready_o=1. After release, a new block completes correctly.
